// File: rtl/accum_buf_writer_pkg.sv
// accum_buf_writer_pkg: FSM state type and default widths shared with the accumulator buffer.
package accum_buf_writer_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } wr_state_t;
    localparam int DEF_DWIDTH   = 16;
    localparam int DEF_IN_WIDTH = 32;
    localparam int DEF_TILE_LEN = 8;
endpackage

// File: rtl/accum_buf_writer_if.sv
// accum_buf_writer_if: upstream valid/ready port plus the buffer wr_en/din/full port.
interface accum_buf_writer_if
    import accum_buf_writer_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int IN_WIDTH = DEF_IN_WIDTH
);
    logic                in_valid;
    logic [IN_WIDTH-1:0] in_data;
    logic                in_ready;
    logic                buf_wr_en;
    logic [DWIDTH-1:0]   buf_din;
    logic                buf_full;
    modport master (input in_valid, in_data, buf_full, output in_ready, buf_wr_en, buf_din);
    modport slave  (output in_valid, in_data, buf_full, input in_ready, buf_wr_en, buf_din);
endinterface

// File: rtl/accum_buf_writer_sat_narrow.sv
// sat_narrow: combinational signed clamp from IN_WIDTH to DWIDTH, flags when clamping occurs.
module sat_narrow #(
    parameter int DWIDTH   = 16,
    parameter int IN_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0] d,
    output logic [DWIDTH-1:0]   q,
    output logic                sat
);
    logic fits;
    // the value fits when every bit from the target sign bit upward matches
    assign fits = &d[IN_WIDTH-1:DWIDTH-1] | ~|d[IN_WIDTH-1:DWIDTH-1];
    assign sat  = ~fits;
    assign q    = fits ? d[DWIDTH-1:0] : {d[IN_WIDTH-1], {(DWIDTH-1){~d[IN_WIDTH-1]}}};
endmodule

// File: rtl/accum_buf_writer.sv
// accum_buf_writer: streams one tile of partial sums through a one-entry hold register into the buffer.
// Define ACCUM_BUF_WR_SAT_EN for signed saturation and the sticky sat_seen output.
module accum_buf_writer
    import accum_buf_writer_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int IN_WIDTH = DEF_IN_WIDTH,
    parameter int TILE_LEN = DEF_TILE_LEN,
    localparam int CNT_W   = $clog2(TILE_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    accum_buf_writer_if.master  bus,
    output logic                busy,
    output logic                tile_done,
    output logic [CNT_W-1:0]    wr_cnt,
    output logic                start_err
`ifdef ACCUM_BUF_WR_SAT_EN
    ,
    output logic                sat_seen
`endif
);
    wr_state_t          state;
    logic               hold_valid;
    logic [DWIDTH-1:0]  hold_data;
    logic [DWIDTH-1:0]  narrowed;
    logic [CNT_W-1:0]   acc_cnt;
    logic               wr;
    logic               acc;
    logic               begin_tile;
`ifdef ACCUM_BUF_WR_SAT_EN
    logic               clamp;
    sat_narrow #(.DWIDTH(DWIDTH), .IN_WIDTH(IN_WIDTH)) u_sat (.d(bus.in_data), .q(narrowed), .sat(clamp));
`else
    logic               unused_hi;
    assign unused_hi = ^bus.in_data;
    assign narrowed  = bus.in_data[DWIDTH-1:0];
`endif
    assign wr            = hold_valid & ~bus.buf_full;
    // refill is allowed in the same cycle the held word drains
    assign bus.in_ready  = state == STREAM && acc_cnt < CNT_W'(TILE_LEN) && (!hold_valid || !bus.buf_full);
    assign acc           = bus.in_valid & bus.in_ready;
    assign bus.buf_wr_en = wr;
    assign bus.buf_din   = hold_data;
    assign busy          = state != IDLE;
    assign tile_done     = state == DONE;
    assign begin_tile    = state == IDLE && start;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            acc_cnt    <= '0;
            wr_cnt     <= '0;
            start_err  <= 1'b0;
`ifdef ACCUM_BUF_WR_SAT_EN
            sat_seen   <= 1'b0;
`endif
        end else begin
            state      <= state == IDLE   ? (start ? STREAM : IDLE) :
                          state == STREAM ? (wr && wr_cnt == CNT_W'(TILE_LEN - 1) ? DONE : STREAM) : IDLE;
            hold_valid <= acc | (hold_valid & ~wr);
            hold_data  <= acc ? narrowed : hold_data;
            acc_cnt    <= begin_tile ? '0 : acc_cnt + CNT_W'(acc);
            wr_cnt     <= begin_tile ? '0 : wr_cnt + CNT_W'(wr);
            start_err  <= begin_tile ? 1'b0 : start_err | (start && state != IDLE);
`ifdef ACCUM_BUF_WR_SAT_EN
            sat_seen   <= begin_tile ? 1'b0 : sat_seen | (acc & clamp);
`endif
        end
    end
endmodule

// File: tb/tb_accum_buf_writer.sv
// tb_accum_buf_writer: randomized and directed tiles checked against a word-level scoreboard model.
module tb_accum_buf_writer;
    import accum_buf_writer_pkg::*;
    localparam int DW = 16;
    localparam int IW = 32;
    localparam int TL = 8;
    localparam int CW = $clog2(TL + 1);
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, tile_done, start_err;
    logic [CW-1:0] wr_cnt;
`ifdef ACCUM_BUF_WR_SAT_EN
    logic sat_seen;
`endif
    accum_buf_writer_if #(.DWIDTH(DW), .IN_WIDTH(IW)) bus ();
    accum_buf_writer #(.DWIDTH(DW), .IN_WIDTH(IW), .TILE_LEN(TL)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(bus.master),
        .busy(busy), .tile_done(tile_done), .wr_cnt(wr_cnt), .start_err(start_err)
`ifdef ACCUM_BUF_WR_SAT_EN
        , .sat_seen(sat_seen)
`endif
    );
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    logic [IW-1:0] words [TL];
    logic [DW-1:0] wr_log [TL];
    int first_wr, last_wr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    // reference narrowing from the arithmetic rule, not the bit pattern
    function automatic logic [DW-1:0] narrow(input logic [IW-1:0] x, output bit clamp);
        longint v  = longint'($signed(x));
        longint mx = (longint'(1) <<< (DW - 1)) - 1;
        longint mn = -(longint'(1) <<< (DW - 1));
        clamp = 0;
`ifdef ACCUM_BUF_WR_SAT_EN
        if (v > mx) begin clamp = 1; return DW'(mx); end
        if (v < mn) begin clamp = 1; return DW'(mn); end
`endif
        return DW'(v);
    endfunction
    task automatic run_tile(input int vp, input int fmode, input int err_at);
        logic [DW-1:0] exp [TL];
        bit clamp, any_clamp, done_next, fin;
        bit ew, er;
        int idx, widx, cyc, pend;
        any_clamp = 0;
        for (int i = 0; i < TL; i++) begin
            exp[i] = narrow(words[i], clamp);
            any_clamp |= clamp;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.buf_full = 1'b0;
        start = 1'b1;
        #1 chk("idle_ready", bus.in_ready, 0);
        @(posedge clk);
        #1 start = 1'b0;
        chk("start_err_clr", start_err, 0);
        idx = 0; widx = 0; cyc = 0; done_next = 0; fin = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            bus.in_valid = $urandom_range(99) < vp;
            bus.in_data  = idx < TL ? words[idx] : $urandom;
            bus.buf_full = fmode == 0 ? 1'b0 : fmode == 1 ? ($urandom_range(99) < 30) : (cyc >= 3 && cyc <= 6);
            start = cyc == err_at;
            #1;
            pend = idx - widx;
            ew = pend > 0 && !bus.buf_full;
            er = !done_next && idx < TL && (pend == 0 || !bus.buf_full);
            chk("tile_done", tile_done, done_next);
            chk("busy", busy, 1);
            chk("wr_en", bus.buf_wr_en, ew);
            chk("in_ready", bus.in_ready, er);
            chk("wr_cnt", wr_cnt, widx);
            if (pend > 0) chk("din", bus.buf_din, exp[widx]);
            fin = done_next;
            if (ew) begin
                wr_log[widx] = bus.buf_din;
                if (widx == 0) first_wr = cyc;
                if (widx == TL - 1) last_wr = cyc;
                widx++;
            end
            if (bus.in_valid && er) idx++;
            done_next = ew && widx == TL;
            cyc++;
        end
        if (!fin) chk("timeout", 0, 1);
        @(negedge clk);
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.buf_full = 1'b0;
        #1;
        chk("tile_done_end", tile_done, 0);
        chk("busy_end", busy, 0);
        chk("start_err", start_err, err_at >= 0);
`ifdef ACCUM_BUF_WR_SAT_EN
        chk("sat_seen", sat_seen, any_clamp);
`endif
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.buf_full = 1'b0;
        #12;
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_wr_en", bus.buf_wr_en, 0);
        chk("rst_din", bus.buf_din, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", tile_done, 0);
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_start_err", start_err, 0);
        rst = 1'b1;
        for (int i = 0; i < TL; i++) words[i] = IW'(i + 1);
        run_tile(100, 0, -1);
        chk("full_rate_span", last_wr - first_wr, TL - 1);
        for (int i = 0; i < TL; i++) chk("full_rate_word", wr_log[i], i + 1);
        run_tile(100, 2, -1);
        for (int i = 0; i < TL; i++) chk("bp_word", wr_log[i], i + 1);
        for (int i = 0; i < TL; i++) words[i] = $urandom;
        run_tile(100, 0, 2);
        for (int i = 0; i < TL; i++) words[i] = IW'(100 + i);
        run_tile(100, 0, -1);
        words[0] = 32'h0001_2345;
        words[1] = 32'hFFFF_0000;
        for (int i = 2; i < TL; i++) words[i] = IW'(i);
        run_tile(100, 0, -1);
`ifdef ACCUM_BUF_WR_SAT_EN
        chk("narrow_pos", wr_log[0], 16'h7FFF);
        chk("narrow_neg", wr_log[1], 16'h8000);
`else
        chk("narrow_pos", wr_log[0], 16'h2345);
        chk("narrow_neg", wr_log[1], 16'h0000);
`endif
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < TL; i++) words[i] = $urandom_range(3) == 0 ? $urandom : IW'($urandom_range(40000)) - 20000;
            run_tile($urandom_range(40, 100), 1, t == 3 ? 5 : -1);
        end
        begin
            int nw = 0;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            while (nw < 3 && checks < 100000) begin
                @(negedge clk);
                bus.in_valid = 1'b1;
                bus.in_data  = $urandom;
                #1 if (bus.buf_wr_en) nw++;
                if (!busy) begin chk("mid_busy", busy, 1); nw = 3; end
            end
            rst = 1'b0;
            #1;
            chk("mid_rst_ready", bus.in_ready, 0);
            chk("mid_rst_wr_en", bus.buf_wr_en, 0);
            chk("mid_rst_din", bus.buf_din, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_done", tile_done, 0);
            chk("mid_rst_wr_cnt", wr_cnt, 0);
            @(negedge clk);
            rst = 1'b1;
            bus.in_valid = 1'b0;
            #1;
            chk("post_rst_busy", busy, 0);
            chk("post_rst_wr_cnt", wr_cnt, 0);
        end
        for (int i = 0; i < TL; i++) words[i] = IW'(500 + i);
        run_tile(100, 0, -1);
        for (int i = 0; i < TL; i++) chk("fresh_word", wr_log[i], 500 + i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/accum_buf_writer.md
Name: accum_buf_writer

Overview:
Producer side of the accumulator buffer FIFO. It accepts one tile of TILE_LEN partial-sum words from the systolic-array output over a valid/ready handshake. Each word is narrowed from IN_WIDTH to DWIDTH and pushed into the buffer's wr_en/din/full port, honouring backpressure from full. It pulses tile_done once the last word of the tile has been written into the buffer.

Parameters:
DWIDTH, 16, buffer word width (must match the buffer's DWIDTH)
IN_WIDTH, 32, upstream partial-sum width; IN_WIDTH >= DWIDTH
TILE_LEN, 8, words per tile; >= 1
CNT_W, $clog2(TILE_LEN+1), counter width (derived, not overridden)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  one-cycle request to begin a tile; honoured only in IDLE
in_valid  in  1  upstream word valid
in_data  in  IN_WIDTH  upstream signed partial sum
in_ready  out  1  upstream may transfer when in_valid & in_ready
buf_wr_en  out  1  write strobe to buffer
buf_din  out  DWIDTH  word to buffer
buf_full  in  1  buffer full flag
busy  out  1  high in any state other than IDLE
tile_done  out  1  one-cycle pulse after the last write of a tile
wr_cnt  out  CNT_W  words written in the current tile
start_err  out  1  sticky: start seen while busy

Behaviour:
- Reset (rst=0, async): state=IDLE, hold_valid=0, hold_data=0, acc_cnt=0, wr_cnt=0, start_err=0. Outputs: in_ready=0, buf_wr_en=0, buf_din=0, busy=0, tile_done=0.
- FSM states: IDLE, STREAM, DONE.
  - IDLE->STREAM on start. Clears acc_cnt, wr_cnt and start_err.
  - STREAM->DONE at the edge where the write with wr_cnt==TILE_LEN-1 occurs.
  - DONE->IDLE unconditionally after 1 cycle. tile_done=1 only in DONE.
- One-entry holding register (hold_valid, hold_data) sits between upstream and buffer.
- buf_wr_en = hold_valid & !buf_full. buf_din = hold_data. The write happens at the edge where buf_wr_en=1; at that edge hold_valid clears and wr_cnt increments.
- in_ready = (state==STREAM) & (acc_cnt<TILE_LEN) & (!hold_valid | !buf_full). This allows a same-cycle refill while the held word drains.
- Transfer at edge when in_valid & in_ready: hold_data <= narrow(in_data), hold_valid <= 1, acc_cnt increments.
- Simultaneous drain and refill: hold_valid stays 1 and hold_data takes the new word.
- Latency: a word accepted at edge N drives buf_din during cycle N+1. It is written at edge N+1 if buf_full=0.
- Throughput: one word per cycle when buf_full stays 0.
- buf_full=1: hold is kept and buf_wr_en=0. in_ready=0 if hold_valid. No data is lost or duplicated.
- acc_cnt==TILE_LEN: in_ready=0 even if in_valid=1. Extra upstream words are not consumed.
- start while busy: ignored and start_err<=1. start in DONE is also ignored and sets start_err.
- Narrowing without macro: truncation to in_data[DWIDTH-1:0].
- TILE_LEN=1: STREAM lasts until the single write, then DONE.

Optional Feature:
ACCUM_BUF_WR_SAT_EN
- Defined: narrowing is signed saturation. Values > 2^(DWIDTH-1)-1 clamp to the maximum; values < -2^(DWIDTH-1) clamp to the minimum.
- Defined: adds an output sat_seen (1 bit, sticky, cleared on start from IDLE). It is set when any accepted word clamps.
- Undefined: plain truncation and no sat_seen port.

Decomposition:
- Config package: wr_state_t enum (IDLE, STREAM, DONE) and default DWIDTH/IN_WIDTH/TILE_LEN constants shared with the buffer.
- One sub-module, sat_narrow (IN_WIDTH->DWIDTH combinational clamp), instantiated only under the macro.

Test Plan:
- Reset mid-tile: assert rst=0 after 3 writes -> all outputs 0 immediately; after release busy=0 and wr_cnt=0, and the next tile writes 8 fresh words.
- Full-rate tile (TILE_LEN=8, buf_full=0, in_valid=1, data 1..8): start -> buf_wr_en high 8 consecutive cycles with din 1..8, tile_done pulses one cycle after the 8th write, busy falls with it.
- Backpressure: buf_full=1 for cycles 3-6 of the stream -> buf_din holds word 3, in_ready=0, no wr_en. After release, words 3..8 are written in order exactly once.
- Overrun: in_valid held high after the 8th accept -> in_ready=0, acc_cnt stays 8, the 9th word is not consumed.
- Start during STREAM -> ignored and start_err=1. It is cleared on the next start issued in IDLE.
- Narrowing: in_data=32'h0001_2345 -> buf_din=16'h2345 without macro and 16'h7FFF with ACCUM_BUF_WR_SAT_EN. in_data=32'hFFFF_0000 -> 16'h0000 without macro and 16'h8000 with it, sat_seen=1.
